// File: rtl/fifo_word_reader.sv
`default_nettype none
// ============================================================================
// fifo_word_reader: drains a byte fifo and packs N lanes little-endian into a
// valid/ready word stream, with flush of partial words.      Revision: 1.0
// ============================================================================
module fifo_word_reader #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               o_fifo_rd_en,
  input  logic [WIDTH-1:0]   i_fifo_rd_data,
  input  logic               i_fifo_ready_pulse,
  input  logic               i_fifo_empty,
  input  logic               i_flush,
  output logic [WIDTH*N-1:0] o_data,
  output logic [N-1:0]       o_keep,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_busy
);

  localparam int            CW     = $clog2(N + 1);
  localparam logic [CW-1:0] C_FULL = CW'(N);

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_WAIT = 1'b1
  } rd_state_e;

  rd_state_e          state_q, state_d;
  logic [CW-1:0]      byte_cnt_q, byte_cnt_d;
  logic [WIDTH*N-1:0] pack_q, pack_d;
  logic               flush_pend_q, flush_pend_d;
  logic [WIDTH*N-1:0] data_q, data_d;
  logic [N-1:0]       keep_q, keep_d;
  logic               valid_q, valid_d;

  logic               slot_free;
  logic               word_full;
  logic               word_part;
  logic               xfer;
  logic [N-1:0]       lane_mask;
  logic [WIDTH*N-1:0] pack_masked;

  // Lanes below byte_cnt are populated; this is both the keep mask and the data mask.
  generate
    for (genvar k = 0; k < N; k++) begin : g_lane
      assign lane_mask[k] = (CW'(k) < byte_cnt_q);
      assign pack_masked[k*WIDTH +: WIDTH] =
        lane_mask[k] ? pack_q[k*WIDTH +: WIDTH] : '0;
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    pack_d       = pack_q;
    flush_pend_d = flush_pend_q;
    data_d       = data_q;
    keep_d       = keep_q;
    valid_d      = valid_q;

    o_fifo_rd_en = rst_n && (state_q == RD_IDLE) && !i_fifo_empty &&
                   (byte_cnt_q < C_FULL) && !flush_pend_q;

    slot_free = !valid_q || i_ready;
    word_full = (byte_cnt_q == C_FULL);
    word_part = flush_pend_q && (state_q == RD_IDLE) && (byte_cnt_q != '0);
    xfer      = slot_free && (word_full || word_part);

    case (state_q)
      RD_IDLE: begin
        if (o_fifo_rd_en) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        state_d = RD_IDLE;
        // No pulse means the read hit a truly empty fifo behind a stale flag.
        if (i_fifo_ready_pulse) begin
          for (int k = 0; k < N; k++) begin
            if (CW'(k) == byte_cnt_q) pack_d[k*WIDTH +: WIDTH] = i_fifo_rd_data;
          end
          byte_cnt_d = byte_cnt_q + CW'(1);
        end
      end
      default: state_d = RD_IDLE;
    endcase

    // Capture only happens in RD_WAIT and transfer needs a full count or RD_IDLE,
    // so the two never coincide.
    if (xfer) begin
      data_d     = pack_masked;
      keep_d     = lane_mask;
      valid_d    = 1'b1;
      byte_cnt_d = '0;
      pack_d     = '0;
    end else if (i_ready) begin
      valid_d = 1'b0;
    end

    if (flush_pend_q) begin
      if (xfer || ((state_q == RD_IDLE) && (byte_cnt_q == '0))) flush_pend_d = 1'b0;
    end else if (i_flush) begin
      flush_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RD_IDLE;
      byte_cnt_q   <= '0;
      pack_q       <= '0;
      flush_pend_q <= 1'b0;
      data_q       <= '0;
      keep_q       <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      pack_q       <= pack_d;
      flush_pend_q <= flush_pend_d;
      data_q       <= data_d;
      keep_q       <= keep_d;
      valid_q      <= valid_d;
    end
  end

  assign o_data  = data_q;
  assign o_keep  = keep_q;
  assign o_valid = valid_q;
  assign o_busy  = (byte_cnt_q != '0) || (state_q == RD_WAIT) || valid_q || flush_pend_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_word_reader.sv
`default_nettype none
// ============================================================================
// tb_fifo_word_reader: directed bench with a latency-1 fifo model and word
// scoreboard.                                                  Revision: 1.0
// ============================================================================
module tb_fifo_word_reader;

  localparam int WIDTH = 8;
  localparam int N     = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               o_fifo_rd_en;
  logic [WIDTH-1:0]   i_fifo_rd_data;
  logic               i_fifo_ready_pulse;
  logic               i_fifo_empty;
  logic               i_flush = 1'b0;
  logic [WIDTH*N-1:0] o_data;
  logic [N-1:0]       o_keep;
  logic               o_valid;
  logic               i_ready = 1'b0;
  logic               o_busy;

  fifo_word_reader #(.WIDTH(WIDTH), .N(N)) u_dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .o_fifo_rd_en       (o_fifo_rd_en),
    .i_fifo_rd_data     (i_fifo_rd_data),
    .i_fifo_ready_pulse (i_fifo_ready_pulse),
    .i_fifo_empty       (i_fifo_empty),
    .i_flush            (i_flush),
    .o_data             (o_data),
    .o_keep             (o_keep),
    .o_valid            (o_valid),
    .i_ready            (i_ready),
    .o_busy             (o_busy)
  );

  always #5 clk = ~clk;

  // Fifo model: read data and pulse one cycle after an accepted read, registered empty.
  logic [7:0]  fq[$];
  logic        pulse_q = 1'b0;
  logic [7:0]  rdata_q = 8'h00;
  logic        empty_q = 1'b1;
  logic        hold_ne = 1'b0;
  assign i_fifo_empty       = empty_q && !hold_ne;
  assign i_fifo_ready_pulse = pulse_q;
  assign i_fifo_rd_data     = rdata_q;

  int          cyc = 0;
  int          rd_cnt = 0;
  int          refused = 0;
  int          last_rd = -1;
  int          min_gap = 1000;
  int          stable_err = 0;
  logic [31:0] rx_d[$];
  logic [3:0]  rx_k[$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic [3:0]  prev_keep = '0;

  int n_vec = 0;
  int n_err = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (o_fifo_rd_en) begin
      rd_cnt = rd_cnt + 1;
      if (last_rd >= 0 && (cyc - last_rd) < min_gap) min_gap = cyc - last_rd;
      last_rd = cyc;
      if (fq.size() > 0) begin
        rdata_q <= fq.pop_front();
        pulse_q <= 1'b1;
      end else begin
        pulse_q <= 1'b0;
        refused = refused + 1;
      end
    end else begin
      pulse_q <= 1'b0;
    end
    empty_q <= (fq.size() == 0);

    if (rst_n && o_valid && i_ready) begin
      rx_d.push_back(o_data);
      rx_k.push_back(o_keep);
    end
    if (rst_n && prev_stall && (!o_valid || o_data !== prev_data || o_keep !== prev_keep))
      stable_err = stable_err + 1;
    prev_stall = rst_n && o_valid && !i_ready;
    prev_data  = o_data;
    prev_keep  = o_keep;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
  endtask

  task automatic wait_words(input string tag, input int n, input int budget);
    int k = 0;
    while (rx_d.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, rx_d.size(), n);
  endtask

  task automatic check_word(input string tag, input logic [31:0] d, input logic [3:0] k);
    logic [31:0] gd = 'x;
    logic [3:0]  gk = 'x;
    if (rx_d.size() > 0) begin
      gd = rx_d.pop_front();
      gk = rx_k.pop_front();
    end
    check({tag, ".data"}, gd, d);
    check({tag, ".keep"}, gk, k);
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst.valid", o_valid, 0);
    check("rst.data", o_data, 0);
    check("rst.keep", o_keep, 0);
    check("rst.busy", o_busy, 0);
    check("rst.rd_en", o_fifo_rd_en, 0);
    rst_n = 1'b1;

    // Single full word, downstream always ready
    i_ready = 1'b1;
    rd_cnt = 0; last_rd = -1; min_gap = 1000;
    @(negedge clk);
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wait_words("t1.words", 1, 60);
    repeat (5) @(negedge clk);
    check_word("t1", 32'h44332211, 4'b1111);
    check("t1.rd_cnt", rd_cnt, 4);
    check("t1.gap_ge2", (min_gap >= 2), 1);
    check("t1.busy", o_busy, 0);
    check("t1.extra_words", rx_d.size(), 0);
    check("t1.refused", refused, 0);

    // Backpressure: one word held, one packed, four bytes left behind
    i_ready = 1'b0;
    for (int b = 1; b <= 12; b++) push(8'(b));
    repeat (40) @(negedge clk);
    check("t2.valid", o_valid, 1);
    check("t2.held_data", o_data, 32'h04030201);
    check("t2.held_keep", o_keep, 4'b1111);
    check("t2.fifo_left", fq.size(), 4);
    check("t2.rd_en", o_fifo_rd_en, 0);
    check("t2.busy", o_busy, 1);
    i_ready = 1'b1;
    wait_words("t2.words", 3, 80);
    check_word("t2.w0", 32'h04030201, 4'b1111);
    check_word("t2.w1", 32'h08070605, 4'b1111);
    check_word("t2.w2", 32'h0C0B0A09, 4'b1111);
    check("t2.stable", stable_err, 0);
    check("t2.fifo_drained", fq.size(), 0);

    // Partial flush, then next word restarts at lane 0
    repeat (4) @(negedge clk);
    push(8'hAA); push(8'hBB);
    repeat (10) @(negedge clk);
    pulse_flush();
    wait_words("t3.words", 1, 20);
    check_word("t3", 32'h0000BBAA, 4'b0011);
    push(8'hC1);
    repeat (6) @(negedge clk);
    pulse_flush();
    wait_words("t3b.words", 1, 20);
    check_word("t3b", 32'h000000C1, 4'b0001);

    // Flush with nothing held
    repeat (5) @(negedge clk);
    pulse_flush();
    check("t4.busy_pend", o_busy, 1);
    @(negedge clk);
    check("t4.busy", o_busy, 0);
    repeat (5) @(negedge clk);
    check("t4.no_word", rx_d.size(), 0);
    check("t4.valid", o_valid, 0);

    // Stale empty flag: refused reads must not advance the lane count
    hold_ne = 1'b1;
    refused = 0;
    @(negedge clk);
    push(8'h5A);
    repeat (12) @(negedge clk);
    hold_ne = 1'b0;
    repeat (3) @(negedge clk);
    check("t5.stale_read", (refused > 0), 1);
    check("t5.valid", o_valid, 0);
    check("t5.busy", o_busy, 1);
    push(8'h6B); push(8'h7C); push(8'h8D);
    wait_words("t5.words", 1, 40);
    check_word("t5", 32'h8D7C6B5A, 4'b1111);

    // Reset mid-word discards the partial pack
    repeat (4) @(negedge clk);
    push(8'hE1); push(8'hE2);
    repeat (8) @(negedge clk);
    check("t6.busy_pre", o_busy, 1);
    rst_n = 1'b0;
    #1;
    check("t6.rst_valid", o_valid, 0);
    check("t6.rst_busy", o_busy, 0);
    check("t6.rst_rd_en", o_fifo_rd_en, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(8'h10); push(8'h11); push(8'h12); push(8'h13);
    wait_words("t6.words", 1, 40);
    check_word("t6", 32'h13121110, 4'b1111);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_word_reader.md
Name: fifo_word_reader

Overview:
- Drains the byte-wide fifo from its read side and packs N consecutive bytes into one word, little-endian.
- Presents each word on a valid/ready stream to the downstream consumer (command decoder / bus bridge).
- Supports a flush that emits a partial word with a lane-keep mask.
- Tolerates the fifo's 1-cycle read latency and its registered (1-cycle-late) empty flag.

Parameters:
- WIDTH, 8: fifo data width, one lane.
- N, 4: lanes per output word, N >= 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- o_fifo_rd_en  out  1  read request to fifo
- i_fifo_rd_data  in  WIDTH  fifo read data
- i_fifo_ready_pulse  in  1  fifo data-valid pulse, 1 cycle after an accepted read
- i_fifo_empty  in  1  fifo empty flag (registered, lags true state by 1 cycle)
- i_flush  in  1  single-cycle request to emit the partial word
- o_data  out  WIDTH*N  packed word; lane k = bits [k*WIDTH +: WIDTH]
- o_keep  out  N  valid-lane mask for o_data
- o_valid  out  1  word valid
- i_ready  in  1  downstream accept
- o_busy  out  1  block holds or awaits data

Behaviour:
- Interface:
  - Clock is clk; reset is rst_n, asynchronous, active-low.
- Reset values:
  - o_valid=0, o_data=0, o_keep=0, o_busy=0, o_fifo_rd_en=0.
  - Internal: byte_cnt=0, pack register=0, flush_pend=0, read FSM=RD_IDLE.
- Read FSM, states RD_IDLE and RD_WAIT:
  - o_fifo_rd_en is combinational: rst_n && state==RD_IDLE && !i_fifo_empty && byte_cnt<N && !flush_pend. When high, next state is RD_WAIT.
  - RD_WAIT lasts exactly 1 cycle, then returns to RD_IDLE.
  - In RD_WAIT, if i_fifo_ready_pulse=1: lane[byte_cnt] <= i_fifo_rd_data and byte_cnt++.
  - In RD_WAIT, if i_fifo_ready_pulse=0 (read refused because the fifo was truly empty under its stale flag): nothing is captured and byte_cnt is unchanged.
  - i_fifo_ready_pulse outside RD_WAIT is ignored.
  - At most one read is outstanding; throughput is 1 byte per 2 cycles.
- Word transfer:
  - Condition: output slot free, i.e. !o_valid || i_ready (a same-cycle free is allowed), AND either
    - byte_cnt==N (full word), or
    - flush_pend && state==RD_IDLE && byte_cnt>0 (partial word).
  - On transfer:
    - o_data <= pack register, with unused lanes forced to 0.
    - o_keep <= (1<<byte_cnt)-1.
    - o_valid <= 1, byte_cnt <= 0, pack register <= 0, flush_pend <= 0.
  - Back-to-back words at full rate are possible with i_ready held high.
- Output handshake:
  - o_valid falls on i_ready unless a new transfer occurs in the same cycle.
  - o_data and o_keep are stable while o_valid && !i_ready.
- Flush:
  - i_flush sets flush_pend; an i_flush while flush_pend is already set has no extra effect.
  - New reads are blocked while flush_pend=1.
  - If byte_cnt==0 and state==RD_IDLE, flush_pend clears with no output.
  - A flush that arrives in RD_WAIT waits for that read's capture, so the captured byte is included in the partial word.
  - If byte_cnt reaches N, the word goes out as a normal full word and flush_pend clears.
- o_busy = byte_cnt!=0 || state==RD_WAIT || o_valid || flush_pend.
- Reset asserted mid-operation discards the partial word and any pending output immediately. A read still in flight is lost; the fifo pointer has already advanced.

Test Plan:
- Fifo holds 0x11,0x22,0x33,0x44, i_ready=1 -> exactly 4 single-cycle o_fifo_rd_en pulses, each at least 2 cycles apart; one word o_data=0x44332211, o_keep=4'b1111; o_busy=0 afterwards.
- 12 bytes 0x01..0x0C, i_ready=0 -> o_data=0x04030201 held stable, second pack fills, reads stop with 4 bytes left in fifo. Then raise i_ready -> words 0x08070605 then 0x0C0B0A09, no byte lost or duplicated.
- Bytes 0xAA,0xBB then i_flush -> o_data=0x0000BBAA, o_keep=4'b0011; next bytes start at lane 0.
- i_flush with byte_cnt=0 and fifo empty -> no o_valid, flush_pend clears within 1 cycle, o_busy=0.
- Single byte 0x5A written, then the fifo goes empty -> the stale-empty extra o_fifo_rd_en gets no ready_pulse; byte_cnt stays 1; a later 0x6B,0x7C,0x8D yield 0x8D7C6B5A.
- After 2 bytes are captured, pulse rst_n low -> o_valid=0, o_busy=0 during reset; after release, bytes 0x10..0x13 yield a clean 0x13121110 with o_keep=4'b1111.
